// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the IF and MEM requesters onto a byte-wide RAM port,
// issuing one RAM cycle per byte and assembling little-endian read data.
module mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_jump_i,
   output logic              if_ready_o,
   output logic [DATA_W-1:0] if_inst_o,
   output logic              if_busy_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_len_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic              mem_ready_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_wdata_o,
   output logic              ram_we_o,
   input  logic [7:0]        ram_rdata_i
);

   localparam int NB = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        cnt_reg, cnt_next;
   logic [2:0]        len_reg, len_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [DATA_W-1:0] buf_reg, buf_next;
   logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
   logic [7:0]        ram_wdata_reg, ram_wdata_next;
   logic              ram_we_reg, ram_we_next;
   logic              if_ready_reg, if_ready_next;
   logic              mem_ready_reg, mem_ready_next;
   logic [DATA_W-1:0] if_inst_reg, if_inst_next;
   logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;

   logic [2:0]        cnt_inc;
   logic [ADDR_W-1:0] addr_inc;
   logic [DATA_W-1:0] buf_capt;
   logic [7:0]        wbyte [NB];
   logic [2:0]        mem_len_dec;

   // RAM outputs are registered one cycle ahead, so the address for the next
   // byte (cnt + 1) is computed while the current byte is on the port.
   assign cnt_inc  = cnt_reg + 3'd1;
   assign addr_inc = addr_reg + ADDR_W'(cnt_inc);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         // Data returned now belongs to the address driven last cycle: byte cnt-1.
         assign buf_capt[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? ram_rdata_i
                                                                : buf_reg[8*gi +: 8];
         assign wbyte[gi] = wdata_reg[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      case (mem_len_i)
         2'b00:   mem_len_dec = 3'd1;
         2'b01:   mem_len_dec = 3'd2;
         default: mem_len_dec = 3'd4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         len_reg       <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         buf_reg       <= '0;
         ram_addr_reg  <= '0;
         ram_wdata_reg <= '0;
         ram_we_reg    <= 1'b0;
         if_ready_reg  <= 1'b0;
         mem_ready_reg <= 1'b0;
         if_inst_reg   <= '0;
         mem_rdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         len_reg       <= len_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         buf_reg       <= buf_next;
         ram_addr_reg  <= ram_addr_next;
         ram_wdata_reg <= ram_wdata_next;
         ram_we_reg    <= ram_we_next;
         if_ready_reg  <= if_ready_next;
         mem_ready_reg <= mem_ready_next;
         if_inst_reg   <= if_inst_next;
         mem_rdata_reg <= mem_rdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      len_next       = len_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      buf_next       = buf_reg;
      ram_addr_next  = ram_addr_reg;
      ram_wdata_next = ram_wdata_reg;
      ram_we_next    = 1'b0;
      if_ready_next  = 1'b0;
      mem_ready_next = 1'b0;
      if_inst_next   = if_inst_reg;
      mem_rdata_next = mem_rdata_reg;

      case (state_reg)
         IDLE: begin
            // A requester still holding req during its own ready pulse is stale.
            if (mem_req_i && !mem_ready_reg) begin
               state_next    = mem_we_i ? MEM_WR : MEM_RD;
               cnt_next      = '0;
               len_next      = mem_len_dec;
               addr_next     = mem_addr_i;
               wdata_next    = mem_wdata_i;
               buf_next      = '0;
               ram_addr_next = mem_addr_i;
               ram_we_next   = mem_we_i;
               if (mem_we_i) begin
                  ram_wdata_next = mem_wdata_i[7:0];
               end
            end else if (if_req_i && !if_jump_i && !if_ready_reg) begin
               state_next    = IF_RD;
               cnt_next      = '0;
               len_next      = 3'd4;
               addr_next     = if_addr_i;
               buf_next      = '0;
               ram_addr_next = if_addr_i;
            end
         end

         IF_RD, MEM_RD: begin
            if (state_reg == IF_RD && if_jump_i) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc;
               buf_next = buf_capt;
               if (cnt_inc < len_reg) begin
                  ram_addr_next = addr_inc;
               end
               if (cnt_reg == len_reg) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  if (state_reg == IF_RD) begin
                     if_ready_next = 1'b1;
                     if_inst_next  = buf_capt;
                  end else begin
                     mem_ready_next = 1'b1;
                     mem_rdata_next = buf_capt;
                  end
               end
            end
         end

         MEM_WR: begin
            cnt_next = cnt_inc;
            if (cnt_inc < len_reg) begin
               ram_we_next    = 1'b1;
               ram_addr_next  = addr_inc;
               ram_wdata_next = wbyte[cnt_inc[1:0]];
            end else begin
               state_next     = IDLE;
               cnt_next       = '0;
               mem_ready_next = 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign if_ready_o  = if_ready_reg;
   assign if_inst_o   = if_inst_reg;
   assign if_busy_o   = (state_reg == IF_RD);
   assign mem_ready_o = mem_ready_reg;
   assign mem_rdata_o = mem_rdata_reg;
   assign ram_addr_o  = ram_addr_reg;
   assign ram_wdata_o = ram_wdata_reg;
   assign ram_we_o    = ram_we_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random transactions against mem_ctrl, checked
// against a byte-addressed shadow memory and per-access latency rules.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_jump, if_ready, if_busy;
   logic [31:0] if_addr, if_inst;
   logic        mem_req, mem_we, mem_ready;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        ram_we;

   bit   [7:0]  ram [4096];
   bit   [7:0]  model [bit [31:0]];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_inst, exp_rdata;

   mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_jump_i(if_jump),
      .if_ready_o(if_ready), .if_inst_o(if_inst), .if_busy_o(if_busy),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
      .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_ready_o(mem_ready), .mem_rdata_o(mem_rdata),
      .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
      .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) ram[ram_addr[11:0]] <= ram_wdata;
      ram_rdata <= ram[ram_addr[11:0]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [7:0] model_byte(input logic [31:0] a);
      return model.exists(a) ? model[a] : 8'h00;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = model_byte(a + 32'(i));
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".ram_addr"},  ram_addr, 32'h0);
      check({tag, ".ram_wdata"}, 32'(ram_wdata), 32'h0);
      check({tag, ".ram_we"},    32'(ram_we), 32'h0);
      check({tag, ".if_ready"},  32'(if_ready), 32'h0);
      check({tag, ".mem_ready"}, 32'(mem_ready), 32'h0);
      check({tag, ".if_inst"},   if_inst, 32'h0);
      check({tag, ".mem_rdata"}, mem_rdata, 32'h0);
      check({tag, ".if_busy"},   32'(if_busy), 32'h0);
   endtask

   // One MEM access issued in the current (idle) cycle; ends one cycle after ready.
   task automatic do_mem(input logic we, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] wd);
      int n;
      int lat;
      n   = nbytes(len);
      lat = we ? n + 1 : n + 2;
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
      step();
      mem_req = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
      for (int k = 1; k <= lat; k++) begin
         if (k <= n) begin
            check("mem.ram_addr", ram_addr, a + 32'(k - 1));
            if (we) check("mem.ram_wdata", 32'(ram_wdata), 32'(wd[8*(k-1) +: 8]));
         end
         check("mem.ram_we", 32'(ram_we), 32'(we && k <= n));
         check("mem.mem_ready", 32'(mem_ready), 32'(k == lat));
         check("mem.if_busy", 32'(if_busy), 32'h0);
         if (k < lat) step();
      end
      if (we) begin
         for (int i = 0; i < n; i++) model[a + 32'(i)] = wd[8*i +: 8];
      end else begin
         exp_rdata = model_read(a, n);
      end
      check("mem.rdata", mem_rdata, exp_rdata);
      check("mem.if_inst_hold", if_inst, exp_inst);
      $display("mem %s len=%0d addr=%h wdata=%h rdata=%h", we ? "wr" : "rd", n, a, wd, mem_rdata);
      step();
      check("mem.ready_low", 32'(mem_ready), 32'h0);
      check("mem.rdata_hold", mem_rdata, exp_rdata);
   endtask

   // Follows an IF fetch whose accept cycle is the current one.
   task automatic if_track(input logic [31:0] a);
      step();
      if_req = 1'b0; if_addr = $urandom;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) check("if.ram_addr", ram_addr, a + 32'(k - 1));
         check("if.ram_we", 32'(ram_we), 32'h0);
         check("if.busy", 32'(if_busy), 32'(k <= 5));
         check("if.ready", 32'(if_ready), 32'(k == 6));
         check("if.mem_ready", 32'(mem_ready), 32'h0);
         if (k < 6) step();
      end
      exp_inst = model_read(a, 4);
      check("if.inst", if_inst, exp_inst);
      check("if.mem_rdata_hold", mem_rdata, exp_rdata);
      $display("fetch addr=%h inst=%h", a, if_inst);
      step();
      check("if.ready_low", 32'(if_ready), 32'h0);
   endtask

   task automatic do_if(input logic [31:0] a);
      if_req = 1'b1; if_addr = a;
      if_track(a);
   endtask

   initial begin
      logic [31:0] ra;
      int          sel;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; if_jump = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
      exp_inst = '0; exp_rdata = '0;
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      step();
      check_all_zero("post_reset");
      $display("reset done");

      // Word fetch of a known instruction
      do_mem(1'b1, 2'b10, 32'h100, 32'h00100513);
      do_if(32'h100);
      check("fetch_word", if_inst, 32'h00100513);

      // Store/load widths
      do_mem(1'b1, 2'b10, 32'h200, 32'hDEADBEEF);
      do_mem(1'b0, 2'b01, 32'h202, 32'h0);
      check("lh_202", mem_rdata, 32'h0000DEAD);
      do_mem(1'b1, 2'b00, 32'h201, 32'h12345655);
      do_mem(1'b0, 2'b10, 32'h200, 32'h0);
      check("lw_200", mem_rdata, 32'hDEAD55EF);

      // Simultaneous MEM and IF requests; MEM req held stale through its ready
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h200;
      if_req = 1'b1; if_addr = 32'h100;
      for (int k = 1; k <= 13; k++) begin
         step();
         check("arb.mem_ready", 32'(mem_ready), 32'(k == 6));
         check("arb.if_ready", 32'(if_ready), 32'(k == 12));
         check("arb.if_busy", 32'(if_busy), 32'(k >= 7 && k <= 11));
         check("arb.ram_we", 32'(ram_we), 32'h0);
         if (k <= 4) check("arb.mem_addr", ram_addr, 32'h200 + 32'(k - 1));
         if (k >= 7 && k <= 10) check("arb.if_addr", ram_addr, 32'h100 + 32'(k - 7));
         if (k == 6) begin
            exp_rdata = model_read(32'h200, 4);
            check("arb.mem_rdata", mem_rdata, exp_rdata);
         end
         if (k == 12) begin
            exp_inst = model_read(32'h100, 4);
            check("arb.if_inst", if_inst, exp_inst);
         end
         if (k == 7) begin
            mem_req = 1'b0; if_req = 1'b0;
         end
      end
      $display("arbitration mem_rdata=%h if_inst=%h", mem_rdata, if_inst);

      // Jump during IF_RD at cnt=2, new PC presented with the jump
      do_mem(1'b1, 2'b10, 32'h400, 32'h12345678);
      if_req = 1'b1; if_addr = 32'h100;
      step();
      if_req = 1'b0;
      step(); step();
      check("jmp.busy_before", 32'(if_busy), 32'h1);
      if_jump = 1'b1; if_req = 1'b1; if_addr = 32'h400;
      step();
      if_jump = 1'b0;
      check("jmp.busy_after", 32'(if_busy), 32'h0);
      check("jmp.no_ready", 32'(if_ready), 32'h0);
      $display("jump abort at cnt=2");
      if_track(32'h400);

      // Jump in the capture cycle cancels the ready pulse
      if_req = 1'b1; if_addr = 32'h200;
      step();
      if_req = 1'b0;
      repeat (4) step();
      if_jump = 1'b1;
      step();
      if_jump = 1'b0;
      check("jmp_capt.no_ready", 32'(if_ready), 32'h0);
      check("jmp_capt.inst_hold", if_inst, exp_inst);
      check("jmp_capt.busy", 32'(if_busy), 32'h0);
      step();
      check("jmp_capt.no_ready2", 32'(if_ready), 32'h0);
      $display("jump abort at capture cycle");

      // Jump with request in IDLE is not accepted; next cycle is
      if_jump = 1'b1; if_req = 1'b1; if_addr = 32'h100;
      step();
      if_jump = 1'b0;
      check("jmp_idle.busy", 32'(if_busy), 32'h0);
      if_track(32'h100);

      // Reset during byte 2 of a word store
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h208; mem_wdata = 32'hA1B2C3D4;
      step();
      mem_req = 1'b0;
      step(); step();
      check("rst_wr.we", 32'(ram_we), 32'h1);
      check("rst_wr.addr", ram_addr, 32'h20A);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all_zero("rst_wr");
      model[32'h208] = 8'hD4; model[32'h209] = 8'hC3; model[32'h20A] = 8'hB2;
      exp_inst = '0; exp_rdata = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("rst_wr.no_ready", 32'(mem_ready), 32'h0);
      end
      $display("reset mid-write");
      do_mem(1'b0, 2'b10, 32'h208, 32'h0);
      check("rst_wr.readback", mem_rdata, 32'h00B2C3D4);

      // Address wrap at the top of the space
      do_mem(1'b1, 2'b10, 32'hFFFFFFFE, 32'h44332211);
      do_mem(1'b0, 2'b11, 32'hFFFFFFFE, 32'h0);
      check("lw_wrap", mem_rdata, 32'h44332211);

      // Random mix
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 2));
         ra  = 32'h800 + 32'($urandom_range(0, 255));
         if (sel == 0) do_if(ra);
         else do_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
